operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DW, default 32, data width of register contents.
REQ-002 Parameter AW, default 5, register address width (2**AW registers).
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  issue request valid.
REQ-006 Port in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
REQ-007 Port in_rs, in_rt  input  AW each  source register addresses.
REQ-008 Port in_rd  input  AW  destination register address.
REQ-009 Port in_wen  input  1  request will write in_rd.
REQ-010 Port rf_ra1, rf_ra2  output  AW each  register-file read addresses, driven from held rs/rt.
REQ-011 Port rf_rd1, rf_rd2  input  DW each  register-file read data, combinational from rf_ra1/rf_ra2.
REQ-012 Port wb_valid, wb_addr, wb_data  input  1/AW/DW  writeback event to the register file.
REQ-013 Port out_valid  output  1  operands valid.
REQ-014 Port out_ready  input  1  downstream consumes when out_valid && out_ready.
REQ-015 Port out_a, out_b, out_rd  output  DW/DW/AW  operand values and passed-through destination.

Function
REQ-016 SHALL implement FSM states EMPTY, WAIT, FULL.
REQ-017 in_ready SHALL be 1 in EMPTY, out_ready in FULL, 0 in WAIT.
REQ-018 On accept, the block SHALL latch rs, rt, rd and wen and evaluate hazards against the scoreboard in the following cycles.
REQ-019 The scoreboard SHALL hold one pending bit per register; accepting a request with wen=1 and rd!=0 SHALL set bit rd.
REQ-020 wb_valid SHALL clear bit wb_addr; wb to a non-pending register SHALL be ignored.
REQ-021 If set and clear target the same register in the same cycle, set SHALL win.
REQ-022 A source SHALL be hazarded when its pending bit is set, excluding the bit set by the request itself.
REQ-023 Register 0 SHALL read as 0 and never hazard.
REQ-024 Without hazard, out_valid SHALL rise the cycle after accept (latency 1); with hazard the FSM SHALL enter WAIT.
REQ-025 WAIT->FULL SHALL occur on the edge where all hazards resolve; operands captured on that edge.
REQ-026 out_a/out_b/out_rd SHALL stay stable while out_valid && !out_ready.
REQ-027 FULL with out_ready and in_valid SHALL accept the next request back-to-back; without in_valid go EMPTY.

Reset
REQ-028 While rst_n=0: state EMPTY, scoreboard all 0, out_valid=0, in_ready=0, out_a=out_b=0, out_rd=0, rf_ra1=rf_ra2=0.
REQ-029 Reset mid-WAIT or mid-FULL SHALL discard the request and all pending bits; in_ready=1 the first cycle after deassertion.

Configuration
REQ-030 Macro OPFETCH_BYPASS_EN defined: wb_data SHALL be forwarded to a hazarded source in the same cycle wb_valid matches it, resolving the hazard on that edge.
REQ-031 Macro undefined: no forwarding; hazard resolves on the edge after the clearing wb, then the operand is read from rf_rd1/rf_rd2.

Structure
REQ-032 Package opfetch_pkg SHALL hold the FSM state type and DW/AW defaults.
REQ-033 Sub-module opfetch_scoreboard SHALL hold the pending bits with set/clear ports and two hazard query ports.

Verification
REQ-034 Reset, then rs=1 rt=2 (RF 0x11/0x22), no pending -> out_valid next cycle, out_a=0x11, out_b=0x22.
REQ-035 Accept rd=3 wen=1, then rs=3 -> WAIT; wb addr=3 data=0xABCD -> out_a=0xABCD same edge (BYPASS_EN) or one cycle later (undefined).
REQ-036 rs=0 rt=0 with bit 0 requested via wen=1 rd=0 -> no hazard, out_a=out_b=0.
REQ-037 out_ready=0 for 5 cycles in FULL -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back accept.
REQ-038 wb to register 4 on the cycle a request with rd=4 wen=1 is accepted -> bit 4 remains set.
REQ-039 rst_n low during WAIT -> out_valid=0, scoreboard clear, next request with prior hazard source completes in 1 cycle.

Source files
------------

// File: rtl/opfetch_pkg.sv
// opfetch_pkg: FSM state type and default widths shared by operand_fetch and its scoreboard.
package opfetch_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  typedef enum logic [1:0] {EMPTY, WAIT, FULL} state_t;
endpackage

// File: rtl/opfetch_scoreboard.sv
// opfetch_scoreboard: one pending bit per register, set wins over clear, register 0 never pending.
module opfetch_scoreboard import opfetch_pkg::*; #(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] qa_addr_i,
  input  logic [AW-1:0] qb_addr_i,
  output logic          qa_hz_o,
  output logic          qb_hz_o
);
  logic [2**AW-1:0] pend_q, pend_d;
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i && set_addr_i != '0) pend_d[set_addr_i] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_q <= '0;
    else pend_q <= pend_d;
  // a register being written back this cycle is already safe to read after the edge
  assign qa_hz_o = qa_addr_i != '0 && pend_q[qa_addr_i] && !(clr_en_i && clr_addr_i == qa_addr_i);
  assign qb_hz_o = qb_addr_i != '0 && pend_q[qb_addr_i] && !(clr_en_i && clr_addr_i == qb_addr_i);
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: holds one issued request, waits out RAW hazards, presents operands.
// Define OPFETCH_BYPASS_EN to forward writeback data into a waiting source on the resolving edge.
module operand_fetch import opfetch_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic          in_wen,
  output logic [AW-1:0] rf_ra1,
  output logic [AW-1:0] rf_ra2,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [AW-1:0] out_rd
);
  state_t state_q;
  logic [AW-1:0] rs_q, rt_q, rd_q;
  logic wen_q, ha_q, hb_q, cap_q;
  logic [DW-1:0] a_q, b_q, op_a, op_b;
  logic accept, hz_a, hz_b, hit_a, hit_b, go, set_en;
  assign in_ready = rst_n && (state_q == EMPTY || (state_q == FULL && out_ready));
  assign accept = in_valid && in_ready;
  assign hit_a = wb_valid && wb_addr == rs_q;
  assign hit_b = wb_valid && wb_addr == rt_q;
`ifdef OPFETCH_BYPASS_EN
  assign go = (!ha_q || hit_a) && (!hb_q || hit_b);
  assign op_a = ha_q && hit_a ? wb_data : rs_q == '0 ? '0 : rf_rd1;
  assign op_b = hb_q && hit_b ? wb_data : rt_q == '0 ? '0 : rf_rd2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign go = !ha_q && !hb_q;
  assign op_a = rs_q == '0 ? '0 : rf_rd1;
  assign op_b = rt_q == '0 ? '0 : rf_rd2;
`endif
  // a waited-on source aliasing our own rd: its writeback must not drop our pending bit
  assign set_en = accept ? in_wen : state_q == WAIT && wen_q && wb_valid && wb_addr == rd_q;
  opfetch_scoreboard #(.AW(AW)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (set_en),
    .set_addr_i(accept ? in_rd : rd_q),
    .clr_en_i  (wb_valid),
    .clr_addr_i(wb_addr),
    .qa_addr_i (in_rs),
    .qb_addr_i (in_rt),
    .qa_hz_o   (hz_a),
    .qb_hz_o   (hz_b)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
      wen_q <= 1'b0;
      ha_q <= 1'b0;
      hb_q <= 1'b0;
      cap_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      rs_q <= in_rs;
      rt_q <= in_rt;
      rd_q <= in_rd;
      wen_q <= in_wen;
      ha_q <= hz_a;
      hb_q <= hz_b;
      cap_q <= 1'b0;
      state_q <= hz_a || hz_b ? WAIT : FULL;
    end else if (state_q == FULL && out_ready) begin
      state_q <= EMPTY;
    end else if (state_q == WAIT) begin
      ha_q <= ha_q && !hit_a;
      hb_q <= hb_q && !hit_b;
      if (go) begin
        state_q <= FULL;
        a_q <= op_a;
        b_q <= op_b;
        cap_q <= 1'b1;
      end
    end else if (state_q == FULL && !cap_q) begin
      // freeze the combinational read so a stalled output cannot drift
      a_q <= op_a;
      b_q <= op_b;
      cap_q <= 1'b1;
    end
  end
  assign out_valid = state_q == FULL;
  assign out_a = cap_q ? a_q : op_a;
  assign out_b = cap_q ? b_q : op_b;
  assign out_rd = rd_q;
  assign rf_ra1 = rs_q;
  assign rf_ra2 = rt_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed literal checks plus randomized traffic against a request-level model.
module tb_operand_fetch;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0, in_wen = 0, wb_valid = 0, out_ready = 0;
  logic [AW-1:0] in_rs = 0, in_rt = 0, in_rd = 0, wb_addr = 0;
  logic [DW-1:0] wb_data = 0;
  logic in_ready, out_valid;
  logic [AW-1:0] rf_ra1, rf_ra2, out_rd;
  logic [DW-1:0] rf_rd1, rf_rd2, out_a, out_b;
  logic [DW-1:0] rf [32];
  int checks = 0, fails = 0;
  bit pend [32];
  bit held, full, need_a, need_b, h_wen;
  logic [AW-1:0] h_rs, h_rt, h_rd;
  logic [DW-1:0] exp_a, exp_b;

  always #5 clk = ~clk;
  assign rf_rd1 = rf[rf_ra1];
  assign rf_rd2 = rf[rf_ra2];

  operand_fetch #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_wen(in_wen),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wb_hits(logic [AW-1:0] s);
    return wb_valid && wb_addr == s;
  endfunction

  // register value as seen after this edge; register 0 always reads zero
  function automatic logic [DW-1:0] rfn(logic [AW-1:0] s);
    return s == 0 ? '0 : wb_hits(s) ? wb_data : rf[s];
  endfunction

  // one request slot: a source waits for the first writeback to a register that was pending
  // when it was accepted; the request's own destination stays pending while it is held
  task automatic model_step();
    bit acc, go;
    if (!rst_n) begin
      foreach (pend[i]) pend[i] = 0;
      held = 0; full = 0; need_a = 0; need_b = 0;
      return;
    end
    acc = in_valid && (!held || (full && out_ready));
    go = 0;
    if (held && !full) begin
      go = BYP ? (!need_a || wb_hits(h_rs)) && (!need_b || wb_hits(h_rt)) : !need_a && !need_b;
      if (wb_hits(h_rs)) need_a = 0;
      if (wb_hits(h_rt)) need_b = 0;
    end
    if (wb_valid) pend[wb_addr] = 0;
    if (acc) begin
      h_rs = in_rs; h_rt = in_rt; h_rd = in_rd; h_wen = in_wen;
      need_a = in_rs != 0 && pend[in_rs];
      need_b = in_rt != 0 && pend[in_rt];
      held = 1;
      full = !need_a && !need_b;
      go = full;
    end else if (full && out_ready) begin
      held = 0; full = 0;
    end else if (go) full = 1;
    if (held && h_wen && h_rd != 0) pend[h_rd] = 1;
    if (go) begin
      exp_a = rfn(h_rs);
      exp_b = rfn(h_rt);
    end
    if (wb_valid) rf[wb_addr] <= wb_data;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'hDEAD; rf[1] = 32'h11; rf[2] = 32'h22; rf[7] = 32'h77;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("in_ready", in_ready, !held || (full && out_ready));
      check("out_valid", out_valid, full);
      if (full) begin
        check("out_a", out_a, exp_a);
        check("out_b", out_b, exp_b);
        check("out_rd", out_rd, h_rd);
      end
    end
  end

  task automatic req(logic [AW-1:0] rs, logic [AW-1:0] rt, logic [AW-1:0] rd, logic wen);
    in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd; in_wen = wen;
  endtask

  task automatic wb(logic [AW-1:0] a, logic [DW-1:0] d);
    wb_valid = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic wait_valid(string name);
    for (int i = 0; i < 4 && !out_valid; i++) @(negedge clk);
    check(name, out_valid, 1);
  endtask

  // write back only registers whose writer has left, or that the held request is waiting on
  task automatic pick_wb();
    logic [AW-1:0] r;
    wb_valid = 0;
    if ($urandom_range(0, 1) == 1)
      for (int k = 0; k < 8; k++) begin
        r = AW'($urandom_range(1, 7));
        if (pend[r] && !(held && h_wen && h_rd == r && !((need_a && h_rs == r) || (need_b && h_rt == r)))) begin
          wb(r, $urandom);
          break;
        end
      end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_ra1", rf_ra1, 0);
    check("rst_ra2", rf_ra2, 0);
    #2 rst_n = 1; req(1, 2, 5, 0);
    @(negedge clk);
    check("lat1_valid", out_valid, 1);
    check("lat1_a", out_a, 32'h11);
    check("lat1_b", out_b, 32'h22);
    #2 in_valid = 0; out_ready = 1;
    @(negedge clk);
    #2 req(0, 0, 3, 1);
    @(negedge clk);
    #2 req(3, 0, 6, 0);
    @(negedge clk);
    check("haz_wait_valid", out_valid, 0);
    check("haz_wait_ready", in_ready, 0);
    #2 in_valid = 0; out_ready = 0; wb(3, 32'hABCD);
    @(negedge clk);
    check("wb_edge_valid", out_valid, BYP);
    #2 wb_valid = 0;
    @(negedge clk);
    check("wb_late_valid", out_valid, 1);
    check("wb_a", out_a, 32'hABCD);
    check("wb_rd", out_rd, 6);
    #2 out_ready = 1;
    @(negedge clk);
    #2 req(0, 0, 0, 1);
    @(negedge clk);
    check("r0_valid", out_valid, 1);
    check("r0_a", out_a, 0);
    check("r0_b", out_b, 0);
    #2 in_valid = 0;
    @(negedge clk);
    #2 req(1, 2, 9, 0); out_ready = 0;
    @(negedge clk);
    #2 in_valid = 0; wb(1, 32'h99);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_ready", in_ready, 0);
      check("stall_a", out_a, 32'h11);
      check("stall_b", out_b, 32'h22);
      #2 wb_valid = 0;
    end
    out_ready = 1; req(2, 1, 10, 0);
    #1 check("b2b_ready", in_ready, 1);
    @(negedge clk);
    check("b2b_valid", out_valid, 1);
    check("b2b_a", out_a, 32'h22);
    check("b2b_b", out_b, 32'h99);
    check("b2b_rd", out_rd, 10);
    #2 in_valid = 0;
    @(negedge clk);
    #2 req(0, 0, 4, 1); wb(4, 32'h4444);
    @(negedge clk);
    #2 in_valid = 0; wb_valid = 0;
    @(negedge clk);
    #2 req(4, 0, 11, 0);
    @(negedge clk);
    check("setwins_wait", out_valid, 0);
    #2 in_valid = 0; out_ready = 0; wb(4, 32'h4545);
    @(negedge clk);
    #2 wb_valid = 0;
    wait_valid("setwins_timeout");
    check("setwins_a", out_a, 32'h4545);
    #2 out_ready = 1;
    @(negedge clk);
    #2 req(0, 0, 7, 1);
    @(negedge clk);
    #2 in_valid = 0;
    @(negedge clk);
    #2 req(7, 0, 12, 0);
    @(negedge clk);
    check("rstwait_wait", out_valid, 0);
    #2 in_valid = 0; rst_n = 0;
    #1 check("rstwait_valid", out_valid, 0);
    check("rstwait_ready", in_ready, 0);
    @(negedge clk);
    #2 rst_n = 1; req(7, 0, 12, 0); out_ready = 0;
    @(negedge clk);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_a", out_a, 32'h77);
    for (int c = 0; c < 3000; c++) begin
      #2;
      rst_n = c != 1500;
      in_valid = $urandom_range(0, 99) < 60;
      in_rs = AW'($urandom_range(0, 7));
      in_rt = AW'($urandom_range(0, 7));
      in_rd = AW'($urandom_range(0, 7));
      in_wen = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 99) < 70;
      pick_wb();
      @(negedge clk);
    end
    #2 in_valid = 0; wb_valid = 0; rst_n = 1;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
